ldpc_trial_seq: RTL and testbench

LDPC_TRIAL_SEQ -- requirements
Module: ldpc_trial_seq

---
 rtl/ldpc_trial_seq.sv | 173 +++++++++++++++++
 tb/tb_ldpc_trial_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_trial_seq.sv
// LDPC Monte-Carlo trial sequencer: LFSR message generation, random error injection,
// decoder launch/timeout supervision and saturating pass/fail/timeout statistics.
module ldpc_trial_seq #(
    parameter int unsigned MM  = 168,
    parameter int unsigned NN  = 208,
    parameter int unsigned TMO = 4096,
    parameter int unsigned PW  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [31:0]       num_trials_i,
    input  logic [7:0]        num_errs_i,
    input  logic [31:0]       seed_i,
    output logic [NN-MM-1:0]  msg_o,
    input  logic [NN-1:0]     cword_i,
    input  logic              cword_valid_i,
    output logic [NN-1:0]     err_mask_o,
    output logic              start_dec_o,
    input  logic              dec_done_i,
    input  logic [NN-1:0]     dec_word_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       trial_cnt_o,
    output logic [31:0]       pass_cnt_o,
    output logic [31:0]       fail_cnt_o,
    output logic [31:0]       tmo_cnt_o
);
    localparam int unsigned MW   = NN - MM;
    localparam int unsigned CW   = $clog2(TMO + MW + 4) + 1;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE, GEN_MSG, WAIT_ENC, INJECT, LAUNCH, WAIT_DEC, CHECK, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     lfsr_q, num_trials_q;
    logic [7:0]      num_errs_q, inj_cnt_q, target;
    logic [CW-1:0]   cnt_q;
    logic [NN-1:0]   ref_q;
    logic            tmo_flag_q;
    logic [PW-1:0]   pos;
    logic            inj_set, inj_done, enc_ok, dec_seen, tmo_hit;
    logic [31:0]     lfsr_step, trial_inc;
    logic            busy_d, done_d, start_dec_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    assign pos       = lfsr_q[PW-1:0];
    assign target    = (32'(num_errs_q) < NN) ? num_errs_q : 8'(NN);
    // A candidate position is rejected when out of range or already flipped
    assign inj_set   = (32'(pos) < NN) && !err_mask_o[pos] && (inj_cnt_q != target);
    assign inj_done  = (target == 8'd0) || (inj_set && ((inj_cnt_q + 8'd1) == target));
    assign enc_ok    = cword_valid_i && (cnt_q >= CW'(2));
    assign dec_seen  = dec_done_i && (cnt_q != '0);
    assign tmo_hit   = !dec_seen && (cnt_q == CW'(TMO - 1));
    assign trial_inc = sat_inc(trial_cnt_o);

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) state_d = (num_trials_i == 32'd0) ? DONE : GEN_MSG;
                GEN_MSG:    if (cnt_q == CW'(MW - 1)) state_d = WAIT_ENC;
                WAIT_ENC:   if (enc_ok) state_d = INJECT;
                INJECT:     if (inj_done) state_d = LAUNCH;
                LAUNCH:     state_d = WAIT_DEC;
                WAIT_DEC:   if (dec_seen || tmo_hit) state_d = CHECK;
                CHECK:      state_d = (trial_inc == num_trials_q) ? DONE : GEN_MSG;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Output decode from the next state so the flags are registered
    always_comb begin
        busy_d      = 1'b1;
        done_d      = 1'b0;
        start_dec_d = 1'b0;
        case (state_d)
            IDLE:    busy_d = 1'b0;
            DONE:    begin busy_d = 1'b0; done_d = 1'b1; end
            LAUNCH:  start_dec_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath, statistics and registered outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            start_dec_o  <= 1'b0;
            msg_o        <= '0;
            err_mask_o   <= '0;
            trial_cnt_o  <= '0;
            pass_cnt_o   <= '0;
            fail_cnt_o   <= '0;
            tmo_cnt_o    <= '0;
            lfsr_q       <= 32'd1;
            num_trials_q <= '0;
            num_errs_q   <= '0;
            inj_cnt_q    <= '0;
            cnt_q        <= '0;
            ref_q        <= '0;
            tmo_flag_q   <= 1'b0;
        end else begin
            busy_o      <= busy_d;
            done_o      <= done_d;
            start_dec_o <= start_dec_d;
            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != '1)    cnt_q <= cnt_q + CW'(1);
            if (!abort_i) begin
                case (state_q)
                    IDLE, DONE: if (start_i) begin
                        num_trials_q <= num_trials_i;
                        num_errs_q   <= num_errs_i;
                        lfsr_q       <= (seed_i == 32'd0) ? 32'd1 : seed_i;
                        trial_cnt_o  <= '0;
                        pass_cnt_o   <= '0;
                        fail_cnt_o   <= '0;
                        tmo_cnt_o    <= '0;
                        err_mask_o   <= '0;
                        inj_cnt_q    <= '0;
                        tmo_flag_q   <= 1'b0;
                    end
                    GEN_MSG: begin
                        msg_o      <= {msg_o[NN-MM-2:0], lfsr_q[0]};
                        lfsr_q     <= lfsr_step;
                        inj_cnt_q  <= '0;
                        tmo_flag_q <= 1'b0;
                    end
                    WAIT_ENC: if (enc_ok) ref_q <= cword_i;
                    INJECT: begin
                        lfsr_q <= lfsr_step;
                        if (inj_set) begin
                            err_mask_o[pos] <= 1'b1;
                            inj_cnt_q       <= inj_cnt_q + 8'd1;
                        end
                    end
                    WAIT_DEC: if (tmo_hit) tmo_flag_q <= 1'b1;
                    CHECK: begin
                        trial_cnt_o <= trial_inc;
                        if (tmo_flag_q) begin
                            fail_cnt_o <= sat_inc(fail_cnt_o);
                            tmo_cnt_o  <= sat_inc(tmo_cnt_o);
                        end else if (dec_word_i == ref_q) begin
                            pass_cnt_o <= sat_inc(pass_cnt_o);
                        end else begin
                            fail_cnt_o <= sat_inc(fail_cnt_o);
                        end
                        if (state_d == GEN_MSG) err_mask_o <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ldpc_trial_seq.sv
// Directed bench for ldpc_trial_seq with an encoder echo, a scripted decoder and an
// independent LFSR/injection model predicting msg_o and err_mask_o at every launch.
module tb_ldpc_trial_seq;
    localparam int NN = 208;
    localparam int MM = 168;
    localparam int MW = NN - MM;

    logic            clk, rst, start_i, abort_i, cword_valid_i, dec_done_i;
    logic [31:0]     num_trials_i, seed_i;
    logic [7:0]      num_errs_i;
    logic [MW-1:0]   msg_o;
    logic [NN-1:0]   cword_i, err_mask_o, dec_word_i;
    logic            start_dec_o, busy_o, done_o;
    logic [31:0]     trial_cnt_o, pass_cnt_o, fail_cnt_o, tmo_cnt_o;

    int              errors = 0;
    int              checks = 0;
    int              launches;
    int              cyc;
    logic [31:0]     m_lfsr;
    logic [MW-1:0]   launch_msg;
    logic [3:0]      nib;
    logic [NN-1:0]   flip;

    ldpc_trial_seq #(.MM(MM), .NN(NN), .TMO(16), .PW(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .abort_i(abort_i),
        .num_trials_i(num_trials_i), .num_errs_i(num_errs_i), .seed_i(seed_i),
        .msg_o(msg_o), .cword_i(cword_i), .cword_valid_i(cword_valid_i),
        .err_mask_o(err_mask_o), .start_dec_o(start_dec_o), .dec_done_i(dec_done_i),
        .dec_word_i(dec_word_i), .busy_o(busy_o), .done_o(done_o),
        .trial_cnt_o(trial_cnt_o), .pass_cnt_o(pass_cnt_o),
        .fail_cnt_o(fail_cnt_o), .tmo_cnt_o(tmo_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [NN-1:0] enc(input logic [MW-1:0] m);
        return {{5{m}}, 8'hA5};
    endfunction

    // One trial of message generation and error injection, continuing from m_lfsr
    task automatic model_trial(input int target, output logic [MW-1:0] msg, output logic [NN-1:0] mask);
        int n;
        int pos;
        int guard;
        msg = '0;
        mask = '0;
        for (int i = 0; i < MW; i++) begin
            msg = {msg[MW-2:0], m_lfsr[0]};
            m_lfsr = lstep(m_lfsr);
        end
        n = 0;
        guard = 0;
        do begin
            pos = int'(m_lfsr[7:0]);
            if (n < target && pos < NN && !mask[pos]) begin
                mask[pos] = 1'b1;
                n++;
            end
            m_lfsr = lstep(m_lfsr);
            guard++;
        end while (n < target && guard < 10000);
    endtask

    // mode 0: decoder returns reference, 1: one bit inverted, 2: never signals done
    task automatic run(input logic [31:0] trials, input logic [7:0] errs, input logic [31:0] seed,
                       input int mode, input int budget, input int stop_launch, output int cycles);
        int delay;
        int target;
        bit stop;
        logic [MW-1:0] emsg;
        logic [NN-1:0] emask;
        logic [NN-1:0] refw;
        launches = 0;
        delay = 0;
        stop = 1'b0;
        refw = '0;
        m_lfsr = (seed == 32'd0) ? 32'd1 : seed;
        target = (int'(errs) < NN) ? int'(errs) : NN;
        dec_done_i = 1'b0;
        dec_word_i = '0;
        num_trials_i = trials;
        num_errs_i = errs;
        seed_i = seed;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cycles = 1;
        while (!done_o && cycles < budget && !stop) begin
            cword_i = enc(msg_o);
            if (start_dec_o) begin
                launches++;
                model_trial(target, emsg, emask);
                launch_msg = msg_o;
                check("launch_msg", msg_o, emsg);
                check("launch_mask", err_mask_o, emask);
                check("mask_popcount", $countones(err_mask_o), target);
                refw = enc(msg_o);
                dec_done_i = 1'b0;
                delay = 3;
                stop = (launches == stop_launch);
            end else if (delay > 0) begin
                delay--;
                if (delay == 0 && mode != 2) begin
                    dec_done_i = 1'b1;
                    dec_word_i = (mode == 1) ? (refw ^ flip) : refw;
                end
            end
            if (!stop) begin
                @(negedge clk);
                cycles++;
            end
        end
        if (stop_launch == 0) check("done_reached", done_o, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        flip = '0;
        flip[7] = 1'b1;
        rst = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        num_trials_i = '0;
        num_errs_i = '0;
        seed_i = '0;
        cword_i = '0;
        cword_valid_i = 1'b1;
        dec_done_i = 1'b0;
        dec_word_i = '0;
        #3;
        check("rst_flags", {busy_o, done_o, start_dec_o}, 3'b000);
        check("rst_msg", msg_o, '0);
        check("rst_mask", err_mask_o, '0);
        check("rst_counters", {trial_cnt_o, pass_cnt_o, fail_cnt_o, tmo_cnt_o}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Single clean trial, zero errors
        run(32'd1, 8'd0, 32'd1, 0, 200, 0, cyc);
        nib = launch_msg[39:36];
        check("seed1_msg_msbs", nib, 4'b1101);
        check("t1_launches", launches, 1);
        check("t1_counts", {trial_cnt_o, pass_cnt_o, fail_cnt_o, tmo_cnt_o}, {32'd1, 32'd1, 32'd0, 32'd0});
        check("t1_flags", {busy_o, done_o}, 2'b01);

        // Three trials, five errors, decoder always wrong
        run(32'd3, 8'd5, 32'hDEAD_BEEF, 1, 600, 0, cyc);
        check("t2_launches", launches, 3);
        check("t2_counts", {trial_cnt_o, pass_cnt_o, fail_cnt_o, tmo_cnt_o}, {32'd3, 32'd0, 32'd3, 32'd0});
        repeat (5) @(negedge clk);
        check("t2_hold_done", {done_o, trial_cnt_o, fail_cnt_o}, {1'b1, 32'd3, 32'd3});

        // Decoder never done: two timeouts; zero seed behaves as seed 1
        run(32'd2, 8'd3, 32'd0, 2, 400, 0, cyc);
        check("t3_counts", {trial_cnt_o, pass_cnt_o, fail_cnt_o, tmo_cnt_o}, {32'd2, 32'd0, 32'd2, 32'd2});
        check("t3_min_latency", cyc >= 124, 1'b1);

        // Zero trials: immediate DONE with cleared counters
        run(32'd0, 8'd4, 32'd5, 0, 10, 0, cyc);
        check("t4_cycles", cyc, 1);
        check("t4_launches", launches, 0);
        check("t4_counts", {trial_cnt_o, pass_cnt_o, fail_cnt_o, tmo_cnt_o}, '0);

        // Abort (with a competing start) during WAIT_DEC of trial 2
        run(32'd3, 8'd2, 32'd7, 0, 400, 2, cyc);
        @(negedge clk);
        abort_i = 1'b1;
        start_i = 1'b1;
        num_trials_i = 32'd0;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_flags", {busy_o, done_o, start_dec_o}, 3'b000);
        check("abort_counts", {trial_cnt_o, pass_cnt_o}, {32'd1, 32'd1});
        run(32'd1, 8'd0, 32'd9, 0, 200, 0, cyc);
        check("restart_counts", {trial_cnt_o, pass_cnt_o, fail_cnt_o}, {32'd1, 32'd1, 32'd0});

        // Reference run, then async reset mid-INJECT, then identical rerun
        run(32'd1, 8'd6, 32'h1234_5678, 0, 300, 0, cyc);
        check("ref_pass", pass_cnt_o, 32'd1);
        @(negedge clk);
        num_trials_i = 32'd1;
        num_errs_i = 8'd6;
        seed_i = 32'h1234_5678;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (46) begin
            @(negedge clk);
            cword_i = enc(msg_o);
        end
        check("pre_rst_busy", busy_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_flags", {busy_o, done_o, start_dec_o}, 3'b000);
        check("async_rst_msg", msg_o, '0);
        check("async_rst_mask", err_mask_o, '0);
        check("async_rst_counters", {trial_cnt_o, pass_cnt_o, fail_cnt_o, tmo_cnt_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        run(32'd1, 8'd6, 32'h1234_5678, 0, 300, 0, cyc);
        check("rerun_counts", {trial_cnt_o, pass_cnt_o, fail_cnt_o}, {32'd1, 32'd1, 32'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
